// File: rtl/wallace_pipe.sv
// wallace_pipe: three-stage pipelined unsigned multiplier, out = a * b.
//   Stage 1 registers the operands. Stage 2 forms the partial products,
//   reduces them with a carry-save Wallace tree to two rows, and registers
//   both rows. Stage 3 adds the two rows with a carry-propagate adder.
//   Latency is 3 clocks and throughput is one product per clock.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears every pipeline register
//   a, b  - unsigned operands, WIDTH bits
//   out   - registered 2*WIDTH-bit unsigned product
module wallace_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned PW = 2 * WIDTH;
  // Two spare rows allow the 3:2 group indexing to run past the live rows
  // without going out of range.
  localparam int unsigned NR = WIDTH + 2;

  typedef logic [PW-1:0] row_t;

  logic [WIDTH-1:0] a_q, b_q;
  row_t             sum_q, sum_d;
  row_t             carry_q, carry_d;
  row_t             out_d;

  // Row-level Wallace reduction: at each level, every full group of three
  // rows goes through a 3:2 counter and a leftover pair through a 2:2
  // counter. Carry rows are shifted left by one, so bits pushed past the
  // MSB are dropped, which matches arithmetic modulo 2^PW. The level loop
  // has a fixed bound and stops doing work once only two rows remain.
  always_comb begin
    row_t        rows [NR];
    row_t        nxt  [NR];
    int unsigned n;
    int unsigned m;
    for (int unsigned i = 0; i < NR; i++) begin
      rows[i] = '0;
      nxt[i]  = '0;
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rows[i] = ({PW{b_q[i]}} & row_t'(a_q)) << i;
    end
    n = WIDTH;
    m = 0;
    for (int unsigned lvl = 0; lvl < WIDTH; lvl++) begin
      if (n > 2) begin
        for (int unsigned k = 0; k < NR; k++) begin
          nxt[k] = '0;
        end
        m = 0;
        for (int unsigned g = 0; g < WIDTH / 3 + 1; g++) begin
          if (3 * g + 2 < n) begin
            nxt[m]     = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
            nxt[m + 1] = ((rows[3*g] & rows[3*g+1]) |
                          (rows[3*g] & rows[3*g+2]) |
                          (rows[3*g+1] & rows[3*g+2])) << 1;
            m = m + 2;
          end else if (3 * g + 1 < n) begin
            nxt[m]     = rows[3*g] ^ rows[3*g+1];
            nxt[m + 1] = (rows[3*g] & rows[3*g+1]) << 1;
            m = m + 2;
          end else if (3 * g < n) begin
            nxt[m] = rows[3*g];
            m = m + 1;
          end
        end
        rows = nxt;
        n    = m;
      end
    end
    sum_d   = rows[0];
    carry_d = rows[1];
  end

  // Final carry-propagate adder; the carry-out is discarded.
  always_comb begin
    out_d = sum_q + carry_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      out     <= '0;
    end else begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      out     <= out_d;
    end
  end

endmodule

// File: tb/tb_wallace_pipe.sv
// tb_wallace_pipe: self-checking bench for wallace_pipe (WIDTH = 32).
//   A reference model keeps a queue of exact products (plain 64-bit
//   multiplication) and is flushed by reset; it is compared against out
//   one time unit after every rising edge. Directed sections pin both the
//   DUT and the model to hand-computed literals.
module tb_wallace_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [63:0] out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  wallace_pipe #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .out  (out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: products enter a queue as operands are sampled; the
  // product sampled three edges ago is the one on out. Reset empties the
  // queue, and until three products have been sampled out must read 0.
  logic [63:0] inflight[$];
  logic [63:0] model_out = '0;
  bit          model_known = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      inflight.delete();
      model_out   = '0;
      model_known = 1'b1;
    end else begin
      inflight.push_back(64'(a) * 64'(b));
      if (inflight.size() >= 3) model_out = inflight.pop_front();
      else                      model_out = '0;
    end
    #1;
    if (model_known) chk("model_vs_out", out, model_out);
  end

  logic [31:0] da [8];
  logic [31:0] db [8];
  logic [63:0] de [8];

  initial begin
    reset = 1'b1;
    a     = '0;
    b     = '0;

    da[0] = 32'd11;         db[0] = 32'd11;         de[0] = 64'd121;
    da[1] = 32'd111;        db[1] = 32'd1111;       de[1] = 64'd123321;
    da[2] = 32'd1111;       db[2] = 32'd111111;     de[2] = 64'd123444321;
    da[3] = 32'd789;        db[3] = 32'd214;        de[3] = 64'd168846;
    da[4] = 32'hFFFFFFFF;   db[4] = 32'hFFFFFFFF;   de[4] = 64'hFFFFFFFE00000001;
    da[5] = 32'h80000000;   db[5] = 32'd2;          de[5] = 64'h0000000100000000;
    da[6] = 32'd0;          db[6] = 32'hDEADBEEF;   de[6] = 64'd0;
    da[7] = 32'd1;          db[7] = 32'hDEADBEEF;   de[7] = 64'h00000000DEADBEEF;

    // Reset held for two edges with nonzero operands.
    @(negedge clk);
    a = 32'd11; b = 32'd11; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_held_out_zero", out, 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("first_after_reset", out, 64'd121);

    // Back-to-back directed stream including the extremes.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        chk($sformatf("stream_out_%0d", i - 3), out, de[i-3]);
        chk($sformatf("stream_model_%0d", i - 3), model_out, de[i-3]);
      end
      if (i < 8) begin
        a = da[i]; b = db[i];
      end else begin
        a = '0; b = '0;
      end
    end

    // Mid-flight reset: three pairs issued, reset sampled on the 2nd and
    // 3rd edges; none of the products may ever appear.
    @(negedge clk);
    a = 32'd5; b = 32'd7; reset = 1'b0;
    @(negedge clk);
    a = 32'd6; b = 32'd8; reset = 1'b1;
    @(negedge clk);
    chk("midflight_reset_out", out, 64'd0);
    a = 32'd9; b = 32'd9;
    @(negedge clk);
    chk("midflight_reset_held", out, 64'd0);
    reset = 1'b0; a = '0; b = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale_product_%0d", i), out, 64'd0);
    end
    a = 32'd3; b = 32'd4;
    @(negedge clk);
    a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("resume_after_reset", out, 64'd12);

    // Random stream with occasional extreme operands and rare reset pulses.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) == 0);
      case ($urandom_range(0, 15))
        0:       a = 32'hFFFFFFFF;
        1:       a = '0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 15))
        0:       b = 32'hFFFFFFFF;
        1:       b = 32'd1;
        default: b = $urandom;
      endcase
    end
    @(negedge clk);
    reset = 1'b0; a = '0; b = '0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
